// File: rtl/ae_program_sequencer.sv
// Fetch/issue sequencer for the autoencoder datapath: walks instruction
// memory, paces each data op through EXEC/WB, and resolves LOOP/HALT itself.
module ae_program_sequencer #(
    parameter int PC_W     = 16,
    parameter int IMEM_LAT = 1,
    parameter int EXEC_CYC = 2,
    parameter int LOOP_W   = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instr_q,
    output logic            sel_en,
    output logic            wb_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_t;

    localparam int CMAX  = (IMEM_LAT > EXEC_CYC) ? IMEM_LAT : EXEC_CYC;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(IMEM_LAT - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);

    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] OP_LSET  = 4'hE;
    localparam logic [3:0] OP_LBACK = 4'hD;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc, pc_d;
    logic [LOOP_W-1:0] loop_cnt, loop_d;
    logic [CNT_W-1:0]  wait_cnt, wait_d;
    logic [15:0]       instr_d;
    logic              err_d;
    logic              advance;
    logic [PC_W-1:0]   pc_inc;
    logic              pc_last;

    assign pc_inc  = pc + 1'b1;
    assign pc_last = &pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            loop_cnt <= '0;
            wait_cnt <= '0;
            instr_q  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            loop_cnt <= loop_d;
            wait_cnt <= wait_d;
            instr_q  <= instr_d;
            err      <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        loop_d  = loop_cnt;
        wait_d  = wait_cnt;
        instr_d = instr_q;
        err_d   = err;
        advance = 1'b0;

        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    loop_d  = '0;
                    wait_d  = '0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                if (wait_cnt == FETCH_LAST) begin
                    instr_d = imem_data;
                    wait_d  = '0;
                    state_d = DECODE;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    instr_q[15:12] == OP_HALT: state_d = HALTED;
                    instr_q[15:12] == OP_LSET: begin
                        loop_d  = LOOP_W'(instr_q[11:0]);
                        advance = 1'b1;
                    end
                    instr_q[15:12] == OP_LBACK: begin
                        if (loop_cnt != '0) begin
                            loop_d  = loop_cnt - 1'b1;
                            pc_d    = PC_W'(instr_q[11:0]);
                            state_d = FETCH;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    default: state_d = EXEC;
                endcase
            end
            EXEC: begin
                if (wait_cnt == EXEC_LAST) begin
                    wait_d  = '0;
                    state_d = WB;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            WB:      advance = 1'b1;
            default: state_d = IDLE;
        endcase

        // Running off the end of the address space ends the program as an error.
        if (advance) begin
            pc_d = pc_inc;
            if (pc_last) begin
                err_d   = 1'b1;
                state_d = HALTED;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_comb begin
        imem_addr = pc;
        sel_en    = (state == EXEC) && (wait_cnt == '0);
        wb_en     = (state == WB);
        busy      = (state != IDLE) && (state != HALTED);
        done      = (state == HALTED);
    end

endmodule

// File: tb/tb_ae_program_sequencer.sv
// Directed bench for ae_program_sequencer: cycle table for a simple
// program plus loop, reset-abort and PC-wrap sequences.
module tb_ae_program_sequencer;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [15:0] imem_addr, imem_data, instr_q;
    logic        sel_en, wb_en, busy, done, err;

    logic        reset_b, start_b;
    logic [1:0]  imem_addr_b;
    logic [15:0] imem_data_b, instr_q_b;
    logic        sel_en_b, wb_en_b, busy_b, done_b, err_b;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign imem_data   = mem_a[imem_addr[3:0]];
    assign imem_data_b = mem_b[imem_addr_b];

    ae_program_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_q(instr_q), .sel_en(sel_en), .wb_en(wb_en),
        .busy(busy), .done(done), .err(err)
    );

    ae_program_sequencer #(.PC_W(2), .IMEM_LAT(2), .EXEC_CYC(1)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .instr_q(instr_q_b), .sel_en(sel_en_b), .wb_en(wb_en_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic        start;
        logic        sel;
        logic        wb;
        logic        busy;
        logic        done;
        logic [15:0] addr;
        logic [15:0] instr;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic s, input logic sl,
                                input logic w, input logic b,
                                input logic d, input logic [15:0] a,
                                input logic [15:0] i);
        vec_t v;
        v.start = s;
        v.sel   = sl;
        v.wb    = w;
        v.busy  = b;
        v.done  = d;
        v.addr  = a;
        v.instr = i;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_a();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic start_a();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic clear_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'hF000;
    endtask

    task automatic run_a(input int bound, output int wbs, output bit ok);
        wbs = 0;
        ok  = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clock);
            if (wb_en) wbs++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int wbs;
        bit ok;
        reset   = 1'b1;
        start   = 1'b0;
        reset_b = 1'b1;
        start_b = 1'b0;
        clear_a();
        mem_b[0] = 16'h1001;
        mem_b[1] = 16'h1002;
        mem_b[2] = 16'h1003;
        mem_b[3] = 16'h1004;
        mem_a[0] = 16'h1234;
        mem_a[1] = 16'hF000;

        tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 1, 0, 16'h0, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 1, 0, 16'h0, 16'h1234);
        tbl[3]  = mk(0, 1, 0, 1, 0, 16'h0, 16'h1234);
        tbl[4]  = mk(1, 0, 0, 1, 0, 16'h0, 16'h1234);
        tbl[5]  = mk(0, 0, 1, 1, 0, 16'h0, 16'h1234);
        tbl[6]  = mk(0, 0, 0, 1, 0, 16'h1, 16'h1234);
        tbl[7]  = mk(0, 0, 0, 1, 0, 16'h1, 16'hF000);
        tbl[8]  = mk(0, 0, 0, 0, 1, 16'h1, 16'hF000);
        tbl[9]  = mk(1, 0, 0, 0, 1, 16'h1, 16'hF000);
        tbl[10] = mk(0, 0, 0, 1, 0, 16'h0, 16'hF000);

        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        reset_b = 1'b0;
        @(negedge clock);
        check("rst_busy",  {31'b0, busy},   0);
        check("rst_done",  {31'b0, done},   0);
        check("rst_err",   {31'b0, err},    0);
        check("rst_wb",    {31'b0, wb_en},  0);
        check("rst_sel",   {31'b0, sel_en}, 0);
        check("rst_instr", {16'b0, instr_q}, 0);
        check("rst_addr",  {16'b0, imem_addr}, 0);
        @(posedge clock);
        #1;

        // Cycle-exact walk of {1234, F000}, with start ignored while busy.
        for (int k = 0; k < 11; k++) begin
            start = tbl[k].start;
            @(negedge clock);
            check($sformatf("c%0d_sel", k),   {31'b0, sel_en}, {31'b0, tbl[k].sel});
            check($sformatf("c%0d_wb", k),    {31'b0, wb_en},  {31'b0, tbl[k].wb});
            check($sformatf("c%0d_busy", k),  {31'b0, busy},   {31'b0, tbl[k].busy});
            check($sformatf("c%0d_done", k),  {31'b0, done},   {31'b0, tbl[k].done});
            check($sformatf("c%0d_err", k),   {31'b0, err},    0);
            check($sformatf("c%0d_addr", k),  {16'b0, imem_addr}, {16'b0, tbl[k].addr});
            check($sformatf("c%0d_instr", k), {16'b0, instr_q},   {16'b0, tbl[k].instr});
            @(posedge clock);
            #1;
        end
        start = 1'b0;

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rs_busy", {31'b0, busy}, 0);
        check("rs_addr", {16'b0, imem_addr}, 0);
        @(posedge clock);
        #1;

        // Loop issuing 0x1111 four times.
        clear_a();
        mem_a[0] = 16'hE003;
        mem_a[1] = 16'h1111;
        mem_a[2] = 16'hD001;
        reset_a();
        start_a();
        run_a(300, wbs, ok);
        check("loop_done", {31'b0, ok}, 1);
        check("loop_wbs",  wbs, 4);
        check("loop_err",  {31'b0, err}, 0);
        check("loop_addr", {16'b0, imem_addr}, 3);

        // LOOP_BACK with zero count falls through.
        clear_a();
        mem_a[0] = 16'hE000;
        mem_a[1] = 16'hD000;
        reset_a();
        start_a();
        run_a(100, wbs, ok);
        check("fall_done",  {31'b0, ok}, 1);
        check("fall_wbs",   wbs, 0);
        check("fall_addr",  {16'b0, imem_addr}, 2);
        check("fall_instr", {16'b0, instr_q}, 16'hF000);

        // LOOP_BACK onto itself spins count+1 times.
        clear_a();
        mem_a[0] = 16'hE002;
        mem_a[1] = 16'hD001;
        reset_a();
        start_a();
        run_a(100, wbs, ok);
        check("spin_done", {31'b0, ok}, 1);
        check("spin_addr", {16'b0, imem_addr}, 2);

        // Reset during EXEC aborts the op without a write-back.
        clear_a();
        mem_a[0] = 16'h1234;
        reset_a();
        start_a();
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (sel_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_sel_seen", {31'b0, ok}, 1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_busy",  {31'b0, busy},   0);
        check("abort_done",  {31'b0, done},   0);
        check("abort_sel",   {31'b0, sel_en}, 0);
        check("abort_wb",    {31'b0, wb_en},  0);
        check("abort_instr", {16'b0, instr_q}, 0);
        check("abort_addr",  {16'b0, imem_addr}, 0);
        wbs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (wb_en) wbs++;
        end
        check("abort_no_wb", wbs, 0);

        // Narrow PC runs off the end: err and done, start clears err.
        @(posedge clock);
        #1 start_b = 1'b1;
        @(posedge clock);
        #1 start_b = 1'b0;
        wbs = 0;
        ok  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (wb_en_b) wbs++;
            if (done_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("wrap_done", {31'b0, ok}, 1);
        check("wrap_wbs",  wbs, 4);
        check("wrap_err",  {31'b0, err_b}, 1);
        check("wrap_busy", {31'b0, busy_b}, 0);
        check("wrap_instr", {16'b0, instr_q_b}, 16'h1004);
        @(posedge clock);
        #1 start_b = 1'b1;
        @(posedge clock);
        #1 start_b = 1'b0;
        @(negedge clock);
        check("wrap_err_clr",  {31'b0, err_b},  0);
        check("wrap_done_clr", {31'b0, done_b}, 0);
        check("wrap_restart",  {31'b0, busy_b}, 1);
        check("wrap_addr0",    {30'b0, imem_addr_b}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
